// File: rtl/pri_queue.sv
// pri_queue: six-entry sorted priority queue of unsigned values.
// The entries r1_out..r6_out form a descending register chain. r1_out is the
// maximum and drives top. A zero entry marks an empty slot. Empty slots always
// sit at the bottom of the chain.
// Command priority each cycle: clear > loadIn > shiftOut > hold.
// Optional feature macro PRI_QUEUE_STATUS_EN adds registered count/full/empty
// status outputs.
module pri_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 6   // chain is built from the six named entry registers
) (
  input  logic             ck,
  input  logic             r,
  input  logic             clear,
  input  logic             loadIn,
  input  logic             shiftOut,
  input  logic [WIDTH-1:0] newVal,
  output logic [WIDTH-1:0] top
`ifdef PRI_QUEUE_STATUS_EN
  ,
  output logic [2:0]       count,
  output logic             full,
  output logic             empty
`endif
);

  // Entry registers; names are kept stable for hierarchical observation.
  logic [WIDTH-1:0] r1_out, r2_out, r3_out, r4_out, r5_out, r6_out;

  logic [WIDTH-1:0] cur_s  [1:DEPTH];  // current chain, indexable view
  logic [WIDTH-1:0] down_s [1:DEPTH];  // value arriving from the slot above
  logic [WIDTH-1:0] up_s   [1:DEPTH];  // value arriving from the slot below
  logic             prv_ge_s [1:DEPTH]; // slot above keeps its value on insert
  logic [WIDTH-1:0] nxt_s  [1:DEPTH];  // next chain contents

  // Gather the named registers into an array for the per-slot logic.
  always_comb begin
    cur_s[1] = r1_out;
    cur_s[2] = r2_out;
    cur_s[3] = r3_out;
    cur_s[4] = r4_out;
    cur_s[5] = r5_out;
    cur_s[6] = r6_out;
  end

  // Neighbour values for insert (shift down) and pop (shift up).
  always_comb begin
    down_s[1]   = newVal;
    prv_ge_s[1] = 1'b1;
    for (int i = 2; i <= DEPTH; i++) begin
      down_s[i]   = cur_s[i-1];
      prv_ge_s[i] = (cur_s[i-1] >= newVal);
    end
    for (int i = 1; i < DEPTH; i++) begin
      up_s[i] = cur_s[i+1];
    end
    up_s[DEPTH] = '0;
  end

  // Per-slot next value. On insert, slots not smaller than newVal hold, which
  // gives stable ties. The first smaller slot takes newVal, and slots below it
  // take their upper neighbour. A zero or too-small newVal changes nothing.
  always_comb begin
    for (int i = 1; i <= DEPTH; i++) begin
      if (clear) begin
        nxt_s[i] = '0;
      end else if (loadIn) begin
        if (cur_s[i] >= newVal) begin
          nxt_s[i] = cur_s[i];
        end else if (prv_ge_s[i]) begin
          nxt_s[i] = newVal;
        end else begin
          nxt_s[i] = down_s[i];
        end
      end else if (shiftOut) begin
        nxt_s[i] = up_s[i];
      end else begin
        nxt_s[i] = cur_s[i];
      end
    end
  end

  // Entry chain registers with asynchronous clear.
  always_ff @(posedge ck or negedge r) begin
    if (!r) begin
      r1_out <= '0;
      r2_out <= '0;
      r3_out <= '0;
      r4_out <= '0;
      r5_out <= '0;
      r6_out <= '0;
    end else begin
      r1_out <= nxt_s[1];
      r2_out <= nxt_s[2];
      r3_out <= nxt_s[3];
      r4_out <= nxt_s[4];
      r5_out <= nxt_s[5];
      r6_out <= nxt_s[6];
    end
  end

  assign top = r1_out;

`ifdef PRI_QUEUE_STATUS_EN
  logic [2:0] count_r, cnt_nxt_s;
  logic       full_r, empty_r;
  logic       accept_s;

  // A load is accepted only when newVal beats the smallest entry. That test
  // also excludes newVal == 0.
  always_comb begin
    accept_s = (cur_s[DEPTH] < newVal);
  end

  // Occupancy tracks the entries: up on accepted load, down on real pop.
  always_comb begin
    if (clear) begin
      cnt_nxt_s = 3'd0;
    end else if (loadIn) begin
      if (accept_s && (count_r != 3'd6)) begin
        cnt_nxt_s = count_r + 3'd1;
      end else begin
        cnt_nxt_s = count_r;
      end
    end else if (shiftOut) begin
      if (count_r != 3'd0) begin
        cnt_nxt_s = count_r - 3'd1;
      end else begin
        cnt_nxt_s = count_r;
      end
    end else begin
      cnt_nxt_s = count_r;
    end
  end

  // Status registers update on the same edge as the entries.
  always_ff @(posedge ck or negedge r) begin
    if (!r) begin
      count_r <= 3'd0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      count_r <= cnt_nxt_s;
      full_r  <= (cnt_nxt_s == 3'd6);
      empty_r <= (cnt_nxt_s == 3'd0);
    end
  end

  assign count = count_r;
  assign full  = full_r;
  assign empty = empty_r;
`endif

endmodule

// File: tb/tb_pri_queue.sv
// Randomised scoreboard bench for pri_queue. The reference model keeps the
// loaded values in a queue, sorts it descending and truncates it to six.
module tb_pri_queue;

  logic       ck = 1'b0;
  logic       r, clear, loadIn, shiftOut;
  logic [7:0] newVal, top;
`ifdef PRI_QUEUE_STATUS_EN
  logic [2:0] count;
  logic       full, empty;
`endif

  pri_queue dut (
    .ck(ck), .r(r), .clear(clear), .loadIn(loadIn), .shiftOut(shiftOut),
    .newVal(newVal), .top(top)
`ifdef PRI_QUEUE_STATUS_EN
    , .count(count), .full(full), .empty(empty)
`endif
  );

  always #5 ck = ~ck;

  typedef struct {
    int e [0:5];
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_x;
  int   model[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int dut_ent(input int i);
    case (i)
      0: return int'(dut.r1_out);
      1: return int'(dut.r2_out);
      2: return int'(dut.r3_out);
      3: return int'(dut.r4_out);
      4: return int'(dut.r5_out);
      5: return int'(dut.r6_out);
      default: return 0;
    endcase
  endfunction

  // Reference behaviour: keep the six largest values, pop the maximum.
  task automatic model_apply(input bit c, input bit l, input bit s, input int v);
    if (c) begin
      model.delete();
    end else if (l) begin
      if (v != 0) begin
        model.push_back(v);
        model.rsort();
        if (model.size() > 6) void'(model.pop_back());
      end
    end else if (s) begin
      if (model.size() > 0) void'(model.pop_front());
    end
  endtask

  function automatic exp_t snap();
    exp_t x;
    for (int i = 0; i < 6; i++) x.e[i] = (i < model.size()) ? model[i] : 0;
    x.cnt = model.size();
    return x;
  endfunction

  // Drive one command for one edge and record what must follow that edge.
  task automatic step(input bit c, input bit l, input bit s, input logic [7:0] v);
    @(negedge ck);
    clear = c; loadIn = l; shiftOut = s; newVal = v;
    @(posedge ck);
    model_apply(c, l, s, int'(v));
    exp_q.push_back(snap());
  endtask

  task automatic load(input logic [7:0] v);
    step(1'b0, 1'b1, 1'b0, v);
  endtask

  task automatic pop();
    step(1'b0, 1'b0, 1'b1, 8'd0);
  endtask

  // Reset pulled 3 ns after an edge; contents must vanish before the next edge.
  task automatic async_reset();
    @(posedge ck);
    #3;
    r = 1'b0;
    clear = 1'b0; loadIn = 1'b0; shiftOut = 1'b0; newVal = 8'd0;
    exp_q.delete();
    model.delete();
    #1;
    for (int i = 0; i < 6; i++) chk($sformatf("async_rst_r%0d", i + 1), dut_ent(i), 0);
    chk("async_rst_top", int'(top), 0);
    @(negedge ck);
    chk("async_rst_hold_top", int'(top), 0);
    #1;
    r = 1'b1;
  endtask

  // Monitor: top is presented every cycle; compare against the scoreboard.
  always @(negedge ck) begin
    if (exp_q.size() > 0) begin
      mon_x = exp_q.pop_front();
      chk("top", int'(top), mon_x.e[0]);
      for (int i = 0; i < 6; i++) chk($sformatf("r%0d_out", i + 1), dut_ent(i), mon_x.e[i]);
      for (int i = 0; i < 5; i++) chk($sformatf("order_r%0d", i + 1), int'(dut_ent(i) >= dut_ent(i + 1)), 1);
`ifdef PRI_QUEUE_STATUS_EN
      chk("count", int'(count), mon_x.cnt);
      chk("full",  int'(full),  int'(mon_x.cnt == 6));
      chk("empty", int'(empty), int'(mon_x.cnt == 0));
`endif
    end
  end

  initial begin
    int dl [0:10];
    int waits;
    dl = '{1, 1, 1, 3, 3, 3, 1, 1, 1, 2, 2};
    r = 1'b0; clear = 1'b0; loadIn = 1'b0; shiftOut = 1'b0; newVal = 8'd0;
    #1;
    chk("reset_top", int'(top), 0);
    for (int i = 0; i < 6; i++) chk($sformatf("reset_r%0d", i + 1), dut_ent(i), 0);
    #12;
    r = 1'b1;

    // Overflow: twenty random loads, then ten pops.
    repeat (20) load(8'($urandom_range(1, 255)));
    repeat (10) pop();

    // Duplicates: stable ties, six largest kept.
    foreach (dl[i]) load(8'(dl[i]));
    repeat (7) pop();

    // Async reset in the middle of ten loads.
    repeat (5) load(8'($urandom_range(1, 255)));
    async_reset();
    repeat (5) load(8'($urandom_range(1, 255)));
    repeat (6) pop();

    // Synchronous clear between two load bursts.
    repeat (5) load(8'($urandom_range(1, 255)));
    step(1'b1, 1'b0, 1'b0, 8'd0);
    repeat (3) load(8'($urandom_range(1, 255)));

    // Command priority.
    step(1'b1, 1'b1, 1'b1, 8'd50);
    step(1'b0, 1'b1, 1'b1, 8'd77);
    pop();

    // Full queue: smaller value dropped, zero ignored, bigger value evicts.
    repeat (6) load(8'd200);
    load(8'd10);
    load(8'd0);
    load(8'd201);
    pop();
    pop();
    step(1'b0, 1'b0, 1'b0, 8'd0);

    // Random mixed traffic.
    repeat (200) begin
      step(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    // Ordering invariant during ten random loads after a clear.
    step(1'b1, 1'b0, 1'b0, 8'd0);
    repeat (10) load(8'($urandom_range(1, 255)));
    step(1'b0, 1'b0, 1'b0, 8'd0);

    waits = 0;
    while (exp_q.size() > 0 && waits < 10) begin
      @(posedge ck);
      waits++;
    end
    if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
